// File: rtl/axilite_bram_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : axilite_bram_responder_if
// Description : AXI4-Lite bus bundle (AW, W, B, AR, R channels) with
//               master and slave views.
// Revision    : 1.0 - initial release
// ============================================================================
interface axilite_bram_responder_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface
`default_nettype wire

// File: rtl/axilite_bram_responder.sv
`default_nettype none
// ============================================================================
// Module      : axilite_bram_responder
// Description : AXI4-Lite slave that turns single-beat reads and writes into
//               accesses on one synchronous single-port BRAM port. One
//               transaction in flight, writes take priority over reads.
// Revision    : 1.0 - initial release
// ============================================================================
module axilite_bram_responder #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int BRAM_ADDR_WIDTH    = C_S_AXI_ADDR_WIDTH - 2
) (
    input  wire logic                          ACLK,
    input  wire logic                          ARESETN,
    axilite_bram_responder_if.slave            s_axi,
    output      logic                          bram_en,
    output      logic [3:0]                    bram_we,
    output      logic [BRAM_ADDR_WIDTH-1:0]    bram_addr,
    output      logic [C_S_AXI_DATA_WIDTH-1:0] bram_din,
    input  wire logic [C_S_AXI_DATA_WIDTH-1:0] bram_dout
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_BRAM = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_BRAM = 3'd3;
    localparam logic [2:0] RD_WAIT = 3'd4;
    localparam logic [2:0] RD_RESP = 3'd5;

    logic [2:0]                    r_state;
    logic                          r_active;   // holds all READYs low during and right after reset
    logic                          r_aw_held;
    logic                          r_w_held;
    logic [BRAM_ADDR_WIDTH-1:0]    r_awaddr;
    logic [BRAM_ADDR_WIDTH-1:0]    r_araddr;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_wdata;
    logic [3:0]                    r_wstrb;
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic                          r_bvalid;
    logic                          r_rvalid;

    logic w_idle;
    logic w_awready;
    logic w_wready;
    logic w_arready;
    logic w_aw_fire;
    logic w_w_fire;
    logic w_ar_fire;
    logic w_wr_go;
    logic w_unused;

    // Handshake readiness; a read is only offered when no write is pending or arriving.
    always_comb begin
        w_idle    = (r_state == IDLE);
        w_awready = r_active && w_idle && !r_aw_held;
        w_wready  = r_active && w_idle && !r_w_held;
        w_arready = r_active && w_idle && !r_aw_held && !r_w_held
                    && !s_axi.awvalid && !s_axi.wvalid;
        w_aw_fire = w_awready && s_axi.awvalid;
        w_w_fire  = w_wready  && s_axi.wvalid;
        w_ar_fire = w_arready && s_axi.arvalid;
        w_wr_go   = (r_aw_held || w_aw_fire) && (r_w_held || w_w_fire);
    end

    // Channel latches, held flags and the transaction state machine.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state   <= IDLE;
            r_active  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awaddr  <= '0;
            r_araddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_bvalid  <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            r_active <= 1'b1;
            if (w_aw_fire) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_w_fire) begin
                r_w_held <= 1'b1;
                r_wdata  <= s_axi.wdata;
                r_wstrb  <= s_axi.wstrb;
            end
            if (w_ar_fire) begin
                r_araddr <= s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            case (r_state)
                IDLE: begin
                    if (w_wr_go) begin
                        r_state <= WR_BRAM;
                    end else if (w_ar_fire) begin
                        r_state <= RD_BRAM;
                    end
                end
                WR_BRAM: begin
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_state   <= WR_RESP;
                end
                WR_RESP: begin
                    // BVALID rises one cycle into the state and drops on the B handshake.
                    if (r_bvalid && s_axi.bready) begin
                        r_bvalid <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_bvalid <= 1'b1;
                    end
                end
                RD_BRAM: begin
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_rdata <= bram_dout;
                    r_state <= RD_RESP;
                end
                RD_RESP: begin
                    // RVALID follows RDATA capture by one cycle; RDATA is frozen here.
                    if (r_rvalid && s_axi.rready) begin
                        r_rvalid <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        r_rvalid <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Bus outputs and BRAM port decode; the BRAM is only touched in the two access states.
    always_comb begin
        s_axi.awready = w_awready;
        s_axi.wready  = w_wready;
        s_axi.arready = w_arready;
        s_axi.bvalid  = r_bvalid;
        s_axi.bresp   = 2'b00;
        s_axi.rvalid  = r_rvalid;
        s_axi.rresp   = 2'b00;
        s_axi.rdata   = r_rdata;
        bram_en       = (r_state == WR_BRAM) || (r_state == RD_BRAM);
        bram_we       = (r_state == WR_BRAM) ? r_wstrb : 4'b0000;
        bram_addr     = (r_state == RD_BRAM) ? r_araddr : r_awaddr;
        bram_din      = r_wdata;
    end

    // Protection bits and the byte offset within a word carry no meaning here.
    assign w_unused = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_axilite_bram_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_axilite_bram_responder
// Description : Directed self-checking bench for axilite_bram_responder with
//               a behavioural byte-writable BRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axilite_bram_responder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        bram_en;
    logic [3:0]  bram_we;
    logic [9:0]  bram_addr;
    logic [31:0] bram_din;
    logic [31:0] bram_dout = '0;
    logic [31:0] mem [0:1023];

    int n_tests   = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int en_pulses = 0;
    int en_cyc    = 0;
    int rv_count  = 0;
    logic [3:0]  last_we   = '0;
    logic [9:0]  last_addr = '0;
    logic [31:0] last_din  = '0;

    axilite_bram_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) s_axi ();

    axilite_bram_responder #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (12)
    ) dut (
        .ACLK      (clk),
        .ARESETN   (rst_n),
        .s_axi     (s_axi),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_din  (bram_din),
        .bram_dout (bram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port BRAM with byte enables, read-before-write.
    always @(posedge clk) begin
        if (bram_en) begin
            for (int b = 0; b < 4; b++) begin
                if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_din[b*8 +: 8];
            end
            bram_dout <= mem[bram_addr];
        end
    end

    // Observe BRAM port activity and RVALID away from the active edge.
    always @(negedge clk) begin
        if (bram_en) begin
            en_pulses <= en_pulses + 1;
            en_cyc    <= cyc;
            last_we   <= bram_we;
            last_addr <= bram_addr;
            last_din  <= bram_din;
        end
        if (s_axi.rvalid) rv_count <= rv_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic axi_write(input logic [11:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int w_lead, input int bdelay,
                             input bit with_ar, input logic [11:0] ar_addr, input string tag);
        int aw_k = -1, w_k = -1, k, bv_k = -1, seen = 0, n = 0, e0;
        bit aw_hs, w_hs, hs;
        logic [1:0] resp = 2'b11;
        e0 = en_pulses;
        @(posedge clk); #1;
        s_axi.awaddr  = addr;
        s_axi.wdata   = data;
        s_axi.wstrb   = strb;
        s_axi.bready  = 1'b0;
        s_axi.wvalid  = 1'b1;
        s_axi.awvalid = (w_lead == 0);
        if (with_ar) begin
            s_axi.araddr  = ar_addr;
            s_axi.arvalid = 1'b1;
        end
        while ((aw_k < 0 || w_k < 0) && n < 50) begin
            @(negedge clk);
            aw_hs = s_axi.awvalid && s_axi.awready;
            w_hs  = s_axi.wvalid && s_axi.wready;
            if (!s_axi.awvalid) check({tag, " awready waiting"}, 32'(s_axi.awready), 32'd1);
            if (w_k >= 0)       check({tag, " wready held"}, 32'(s_axi.wready), 32'd0);
            if (s_axi.arvalid)  check({tag, " arready vs write"}, 32'(s_axi.arready), 32'd0);
            @(posedge clk); #1;
            n++;
            if (aw_hs) begin aw_k = cyc; s_axi.awvalid = 1'b0; end
            if (w_hs)  begin w_k  = cyc; s_axi.wvalid  = 1'b0; end
            if (aw_k < 0 && !s_axi.awvalid && n >= w_lead) s_axi.awvalid = 1'b1;
        end
        if (aw_k < 0 || w_k < 0) begin
            check({tag, " aw/w timeout"}, 32'd0, 32'd1);
            s_axi.awvalid = 1'b0;
            s_axi.wvalid  = 1'b0;
            return;
        end
        k  = (aw_k > w_k) ? aw_k : w_k;
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk);
            if (s_axi.arvalid) check({tag, " arready in B"}, 32'(s_axi.arready), 32'd0);
            if (s_axi.bvalid) begin
                if (bv_k < 0) begin bv_k = cyc; resp = s_axi.bresp; end
                if (seen < bdelay) begin
                    check({tag, " stall awready"}, 32'(s_axi.awready), 32'd0);
                    check({tag, " stall wready"},  32'(s_axi.wready),  32'd0);
                    check({tag, " stall arready"}, 32'(s_axi.arready), 32'd0);
                    check({tag, " stall bresp"},   32'(s_axi.bresp),   32'd0);
                end else begin
                    s_axi.bready = 1'b1;
                end
                seen++;
            end
            hs = s_axi.bvalid && s_axi.bready;
            @(posedge clk); #1;
            n++;
        end
        s_axi.bready = 1'b0;
        if (!hs) check({tag, " B timeout"}, 32'd0, 32'd1);
        check({tag, " bvalid edge"}, 32'(bv_k - k), 32'd2);
        check({tag, " bresp"},       32'(resp), 32'd0);
        check({tag, " bram pulses"}, 32'(en_pulses - e0), 32'd1);
        check({tag, " bram_we"},     32'(last_we), 32'(strb));
        check({tag, " bram_addr"},   32'(last_addr), 32'(addr[11:2]));
        check({tag, " bram_din"},    last_din, data);
        check({tag, " bram_en cyc"}, 32'(en_cyc - k), 32'd0);
    endtask

    task automatic axi_read(input logic [11:0] addr, input logic [31:0] exp,
                            input int rdelay, input string tag);
        int k = -1, rv_k = -1, seen = 0, n = 0, e0;
        bit hs;
        logic [31:0] held = '0;
        logic [1:0]  resp = 2'b11;
        e0 = en_pulses;
        if (!s_axi.arvalid) begin
            @(posedge clk); #1;
        end
        s_axi.araddr  = addr;
        s_axi.arvalid = 1'b1;
        s_axi.rready  = 1'b0;
        while (k < 0 && n < 50) begin
            @(negedge clk);
            hs = s_axi.arvalid && s_axi.arready;
            @(posedge clk); #1;
            n++;
            if (hs) begin k = cyc; s_axi.arvalid = 1'b0; end
        end
        if (k < 0) begin
            check({tag, " ar timeout"}, 32'd0, 32'd1);
            s_axi.arvalid = 1'b0;
            return;
        end
        n  = 0;
        hs = 1'b0;
        while (!hs && n < 50) begin
            @(negedge clk);
            if (s_axi.rvalid) begin
                if (rv_k < 0) begin
                    rv_k = cyc;
                    held = s_axi.rdata;
                    resp = s_axi.rresp;
                end else begin
                    check({tag, " rdata stable"}, s_axi.rdata, held);
                end
                if (seen < rdelay) begin
                    check({tag, " stall awready"}, 32'(s_axi.awready), 32'd0);
                    check({tag, " stall wready"},  32'(s_axi.wready),  32'd0);
                    check({tag, " stall arready"}, 32'(s_axi.arready), 32'd0);
                end else begin
                    s_axi.rready = 1'b1;
                end
                seen++;
            end
            hs = s_axi.rvalid && s_axi.rready;
            @(posedge clk); #1;
            n++;
        end
        s_axi.rready = 1'b0;
        if (!hs) check({tag, " R timeout"}, 32'd0, 32'd1);
        check({tag, " rvalid edge"}, 32'(rv_k - k), 32'd3);
        check({tag, " rdata"},       held, exp);
        check({tag, " rresp"},       32'(resp), 32'd0);
        check({tag, " bram pulses"}, 32'(en_pulses - e0), 32'd1);
        check({tag, " bram_we"},     32'(last_we), 32'd0);
        check({tag, " bram_addr"},   32'(last_addr), 32'(addr[11:2]));
        check({tag, " bram_en cyc"}, 32'(en_cyc - k), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " awready"},   32'(s_axi.awready), 32'd0);
        check({tag, " wready"},    32'(s_axi.wready),  32'd0);
        check({tag, " arready"},   32'(s_axi.arready), 32'd0);
        check({tag, " bvalid"},    32'(s_axi.bvalid),  32'd0);
        check({tag, " rvalid"},    32'(s_axi.rvalid),  32'd0);
        check({tag, " bresp"},     32'(s_axi.bresp),   32'd0);
        check({tag, " rresp"},     32'(s_axi.rresp),   32'd0);
        check({tag, " rdata"},     s_axi.rdata, 32'd0);
        check({tag, " bram_en"},   32'(bram_en),   32'd0);
        check({tag, " bram_we"},   32'(bram_we),   32'd0);
        check({tag, " bram_addr"}, 32'(bram_addr), 32'd0);
        check({tag, " bram_din"},  bram_din, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n, rv0;
        bit hs;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        s_axi.awaddr  = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata   = '0; s_axi.wstrb  = '0; s_axi.wvalid  = 1'b0;
        s_axi.bready  = 1'b0;
        s_axi.araddr  = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0;
        s_axi.rready  = 1'b0;
        #1;
        check_all_zero("reset");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Four writes then read back in order.
        axi_write(12'h000, 32'h1, 4'hF, 0, 0, 1'b0, 12'h0, "wr0");
        axi_write(12'h004, 32'h2, 4'hF, 0, 0, 1'b0, 12'h0, "wr1");
        axi_write(12'h008, 32'h3, 4'hF, 0, 0, 1'b0, 12'h0, "wr2");
        axi_write(12'h00C, 32'h4, 4'hF, 0, 0, 1'b0, 12'h0, "wr3");
        axi_read (12'h000, 32'h1, 0, "rd0");
        axi_read (12'h004, 32'h2, 0, "rd1");
        axi_read (12'h008, 32'h3, 0, "rd2");
        axi_read (12'h00C, 32'h4, 0, "rd3");

        // Byte-strobe merge.
        axi_write(12'h010, 32'hFFFFFFFF, 4'hF, 0, 0, 1'b0, 12'h0, "wr_full");
        axi_write(12'h010, 32'h000000AB, 4'h1, 0, 0, 1'b0, 12'h0, "wr_byte");
        axi_read (12'h010, 32'hFFFFFFAB, 0, "rd_merge");

        // Empty strobe still completes but leaves memory alone; offset bits ignored.
        axi_write(12'h030, 32'h11111111, 4'hF, 0, 0, 1'b0, 12'h0, "wr_pre");
        axi_write(12'h032, 32'h22222222, 4'h0, 0, 0, 1'b0, 12'h0, "wr_nostrb");
        axi_read (12'h031, 32'h11111111, 0, "rd_nostrb");

        // W leads AW by three cycles.
        axi_write(12'h014, 32'h13572468, 4'hF, 3, 0, 1'b0, 12'h0, "wr_wlead");
        axi_read (12'h014, 32'h13572468, 0, "rd_wlead");

        // AW, W and AR together: write wins, read follows.
        axi_write(12'h020, 32'h5A5A5A5A, 4'hF, 0, 0, 1'b1, 12'h020, "wr_simul");
        axi_read (12'h020, 32'h5A5A5A5A, 0, "rd_simul");

        // Response backpressure.
        axi_write(12'h050, 32'hCAFEBABE, 4'hF, 0, 5, 1'b0, 12'h0, "wr_bp");
        axi_read (12'h050, 32'hCAFEBABE, 5, "rd_bp");

        // Reset while the read waits on BRAM data.
        rv0 = rv_count;
        @(posedge clk); #1;
        s_axi.araddr  = 12'h004;
        s_axi.arvalid = 1'b1;
        k = -1; n = 0;
        while (k < 0 && n < 50) begin
            @(negedge clk);
            hs = s_axi.arvalid && s_axi.arready;
            @(posedge clk); #1;
            n++;
            if (hs) k = cyc;
        end
        s_axi.arvalid = 1'b0;
        check("rst ar handshake", 32'(k >= 0), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst rvalid never", 32'(rv_count - rv0), 32'd0);
        axi_write(12'h040, 32'h77777777, 4'hF, 0, 0, 1'b0, 12'h0, "wr_post");
        axi_read (12'h040, 32'h77777777, 0, "rd_post");
        axi_read (12'h004, 32'h2, 0, "rd_post_old");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axilite_bram_responder.md
# axilite_bram_responder

AXI4-Lite slave (responder) that terminates single-beat AXI4-Lite read and write transactions from a master and converts them into accesses on one synchronous single-port BRAM port. It sits between the system AXI4-Lite interconnect (or a VIP master in simulation) and a block RAM used as a shared buffer. It handles one outstanding transaction at a time, with write priority and full BREADY/RREADY backpressure.

## Interface
- C_S_AXI_DATA_WIDTH, 32, AXI and BRAM data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 12, AXI byte-address width.
- BRAM_ADDR_WIDTH, C_S_AXI_ADDR_WIDTH-2, BRAM word-address width.
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake.
- S_AXI_WDATA  in  32  write data.
- S_AXI_WSTRB  in  4  byte strobes.
- S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake.
- S_AXI_BRESP  out  2  always 2'b00 (OKAY).
- S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARPROT  in  3  ignored.
- S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake.
- S_AXI_RDATA  out  32  read data.
- S_AXI_RRESP  out  2  always 2'b00.
- S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake.
- bram_en  out  1  BRAM enable.
- bram_we  out  4  BRAM byte write enables.
- bram_addr  out  BRAM_ADDR_WIDTH  BRAM word address = AXADDR[C_S_AXI_ADDR_WIDTH-1:2].
- bram_din  out  32  BRAM write data.
- bram_dout  in  32  BRAM read data, valid one cycle after bram_en with bram_we=0.

## Operation
- States: IDLE, WR_BRAM, WR_RESP, RD_BRAM, RD_WAIT, RD_RESP.
- Reset: state IDLE; all READY/VALID outputs 0; BRESP, RRESP, RDATA, bram_en, bram_we, bram_addr, bram_din all 0; the aw_held and w_held flags are cleared.
- AWREADY = IDLE and !aw_held. WREADY = IDLE and !w_held. Each handshake latches the address or the data plus strobe and sets its held flag. AW and W are accepted independently and in either order.
- ARREADY = IDLE and !aw_held and !w_held and !AWVALID and !WVALID. This gives writes strict priority.
- IDLE -> WR_BRAM when AW and W are both held or being handshaken on this edge. IDLE -> RD_BRAM on AR handshake.
- WR_BRAM (1 cycle): bram_en=1, bram_we=WSTRB latched, bram_addr and bram_din from latches; clear held flags; -> WR_RESP.
- WR_RESP: BVALID=1 until BREADY is sampled high; then -> IDLE.
- RD_BRAM (1 cycle): bram_en=1, bram_we=0, bram_addr from latched ARADDR; -> RD_WAIT.
- RD_WAIT (1 cycle): capture bram_dout into RDATA; -> RD_RESP.
- RD_RESP: RVALID=1 and RDATA held stable until RREADY is sampled high; then -> IDLE.
- Address bits [1:0] are ignored. There are no out-of-range addresses; every address maps to BRAM. WSTRB=0 performs a write cycle with no bytes written and still returns BVALID.
- bram_en and bram_we are 0 in every state except WR_BRAM and RD_BRAM.

## Timing
- Write: AW and W handshake together at edge k gives bram_we≠0 in cycle k..k+1 and BVALID high from edge k+2. Minimum write turnaround is 3 cycles with BREADY tied high.
- Write with AW and W at different edges: the sequence starts from the later handshake edge.
- Read: AR handshake at edge k gives bram_en in cycle k..k+1, RDATA captured at edge k+2, and RVALID high from edge k+3.
- Backpressure: a VALID, once asserted, is never deasserted before its READY, and the payload does not change while waiting. No new AW, W or AR is accepted until the response completes.
- Simultaneous AWVALID, WVALID and ARVALID in IDLE: the write is accepted and ARREADY stays 0. The read is accepted in the first IDLE cycle with no write pending.
- Asynchronous reset mid-transaction (any state): all outputs go to reset values immediately and the in-flight transaction is dropped. A BRAM write already presented is not rolled back.

## Test plan
- Write 0x1,0x2,0x3,0x4 to addresses 0x0,0x4,0x8,0xC, then read back all four -> RDATA matches in order; BRESP and RRESP are 0; BVALID at edge k+2 and RVALID at edge k+3.
- Write 0xFFFFFFFF to 0x10, then write 0x000000AB with WSTRB=4'b0001, then read 0x10 -> 0xFFFFFFAB.
- WVALID asserted 3 cycles before AWVALID -> WREADY handshake first, AWREADY stays high until AW arrives, exactly one bram_we pulse, single BVALID.
- AWVALID, WVALID and ARVALID asserted in the same cycle at address 0x20 with data 0x5A5A5A5A -> write completes first, then the read returns 0x5A5A5A5A.
- BREADY held low for 5 cycles, then RREADY held low for 5 cycles -> BVALID and RVALID stay high with stable payload, and AWREADY, WREADY and ARREADY stay 0 for the whole wait.
- Assert ARESETN low during RD_WAIT -> RVALID never rises, all outputs are 0, and the next write/read after reset works normally.
